// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, sizes and ALU opcodes for the ALU/branch reservation station.
package alu_reservation_station_pkg;

    localparam int ROB_ID_WIDTH = 4;
    localparam int RS_ALU_SIZE  = 8;
    localparam int ALU_OP_WIDTH = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BEQ = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BNE = 4'd9;

endpackage

// File: rtl/alu_reservation_station_select.sv
// Lowest-index priority encoder: request vector to index plus found flag.
module rs_select #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan from the top so the lowest requesting index is the last to win.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            idx   = req[i] ? W'(i) : idx;
            found = found | req[i];
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU/branch reservation station: holds issued entries until both operands
// arrive over the CDB, then dispatches one ready entry per cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE = RS_ALU_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    output logic                    rs_alu_full,
    input  logic                    rs_alu_we,
    input  logic [ALU_OP_WIDTH-1:0] rs_alu_op,
    input  logic [31:0]             rs_alu_vj,
    input  logic [31:0]             rs_alu_vk,
    input  logic [ROB_ID_WIDTH-1:0] rs_alu_qj,
    input  logic [ROB_ID_WIDTH-1:0] rs_alu_qk,
    input  logic                    rs_alu_qj_valid,
    input  logic                    rs_alu_qk_valid,
    input  logic [ROB_ID_WIDTH-1:0] rs_alu_dest,
    input  logic [31:0]             rs_alu_imm,
    input  logic [31:0]             rs_alu_pc,
    input  logic [31:0]             rs_alu_pred_target,
    input  logic                    cdb_valid,
    input  logic [ROB_ID_WIDTH-1:0] cdb_rob_id,
    input  logic [31:0]             cdb_value,
    output logic                    alu_valid,
    input  logic                    alu_ready,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic [31:0]             alu_vj,
    output logic [31:0]             alu_vk,
    output logic [31:0]             alu_imm,
    output logic [31:0]             alu_pc,
    output logic [31:0]             alu_pred_target,
    output logic [ROB_ID_WIDTH-1:0] alu_dest
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]      busy_r;
    logic [RS_SIZE-1:0]      qjv_r;
    logic [RS_SIZE-1:0]      qkv_r;
    logic [ALU_OP_WIDTH-1:0] op_r   [RS_SIZE];
    logic [31:0]             vj_r   [RS_SIZE];
    logic [31:0]             vk_r   [RS_SIZE];
    logic [31:0]             imm_r  [RS_SIZE];
    logic [31:0]             pc_r   [RS_SIZE];
    logic [31:0]             pt_r   [RS_SIZE];
    logic [ROB_ID_WIDTH-1:0] qj_r   [RS_SIZE];
    logic [ROB_ID_WIDTH-1:0] qk_r   [RS_SIZE];
    logic [ROB_ID_WIDTH-1:0] dest_r [RS_SIZE];

    logic [RS_SIZE-1:0] ready_s;
    logic [RS_SIZE-1:0] free_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic               sel_found_s;
    logic               free_found_s;
    logic               dispatch_s;
    logic               write_s;
    logic               byp_j_s;
    logic               byp_k_s;

    // Readiness, free slots and the per-cycle write/dispatch decisions.
    always_comb begin
        ready_s    = busy_r & ~qjv_r & ~qkv_r;
        free_s     = ~busy_r;
        dispatch_s = sel_found_s && (!alu_valid || alu_ready);
        write_s    = rs_alu_we && free_found_s;
        byp_j_s    = rs_alu_qj_valid && cdb_valid && (cdb_rob_id == rs_alu_qj);
        byp_k_s    = rs_alu_qk_valid && cdb_valid && (cdb_rob_id == rs_alu_qk);
    end

    assign rs_alu_full = &busy_r;

    rs_select #(.N(RS_SIZE), .W(IDX_W)) u_free_sel (
        .req   (free_s),
        .idx   (free_idx_s),
        .found (free_found_s)
    );

    rs_select #(.N(RS_SIZE), .W(IDX_W)) u_ready_sel (
        .req   (ready_s),
        .idx   (sel_idx_s),
        .found (sel_found_s)
    );

    // Entry payload: load on write (with CDB bypass), otherwise CDB wakeup.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (write_s && (free_idx_s == IDX_W'(i))) begin
                op_r[i]   <= rs_alu_op;
                vj_r[i]   <= byp_j_s ? cdb_value : rs_alu_vj;
                vk_r[i]   <= byp_k_s ? cdb_value : rs_alu_vk;
                qjv_r[i]  <= rs_alu_qj_valid && !byp_j_s;
                qkv_r[i]  <= rs_alu_qk_valid && !byp_k_s;
                qj_r[i]   <= rs_alu_qj;
                qk_r[i]   <= rs_alu_qk;
                dest_r[i] <= rs_alu_dest;
                imm_r[i]  <= rs_alu_imm;
                pc_r[i]   <= rs_alu_pc;
                pt_r[i]   <= rs_alu_pred_target;
            end else begin
                if (busy_r[i] && qjv_r[i] && cdb_valid && (qj_r[i] == cdb_rob_id)) begin
                    vj_r[i]  <= cdb_value;
                    qjv_r[i] <= 1'b0;
                end
                if (busy_r[i] && qkv_r[i] && cdb_valid && (qk_r[i] == cdb_rob_id)) begin
                    vk_r[i]  <= cdb_value;
                    qkv_r[i] <= 1'b0;
                end
            end
        end
    end

    // Occupancy and the registered dispatch stage; reset/flush override all.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_r          <= '0;
            alu_valid       <= 1'b0;
            alu_op          <= '0;
            alu_vj          <= 32'd0;
            alu_vk          <= 32'd0;
            alu_imm         <= 32'd0;
            alu_pc          <= 32'd0;
            alu_pred_target <= 32'd0;
            alu_dest        <= '0;
        end else begin
            if (dispatch_s) begin
                alu_valid         <= 1'b1;
                alu_op            <= op_r[sel_idx_s];
                alu_vj            <= vj_r[sel_idx_s];
                alu_vk            <= vk_r[sel_idx_s];
                alu_imm           <= imm_r[sel_idx_s];
                alu_pc            <= pc_r[sel_idx_s];
                alu_pred_target   <= pt_r[sel_idx_s];
                alu_dest          <= dest_r[sel_idx_s];
                busy_r[sel_idx_s] <= 1'b0;
            end else if (alu_ready) begin
                alu_valid <= 1'b0;
            end
            // The free slot is never the dispatched one: it was idle before this edge.
            if (write_s) begin
                busy_r[free_idx_s] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// cycle by cycle against a behavioural entry-table model.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst, flush, rs_alu_full, rs_alu_we;
    logic [3:0]  rs_alu_op, rs_alu_qj, rs_alu_qk, rs_alu_dest;
    logic [31:0] rs_alu_vj, rs_alu_vk, rs_alu_imm, rs_alu_pc, rs_alu_pred_target;
    logic        rs_alu_qj_valid, rs_alu_qk_valid;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_op, alu_dest;
    logic [31:0] alu_vj, alu_vk, alu_imm, alu_pc, alu_pred_target;

    int checks = 0;
    int errors = 0;

    // Reference model: a table of pending instructions plus the output slot.
    bit          m_busy [N];
    logic [3:0]  m_op [N], m_qj [N], m_qk [N], m_dest [N];
    bit          m_qjv [N], m_qkv [N];
    logic [31:0] m_vj [N], m_vk [N], m_imm [N], m_pc [N], m_pt [N];
    bit          e_valid;
    logic [3:0]  e_op, e_dest;
    logic [31:0] e_vj, e_vk, e_imm, e_pc, e_pt;

    alu_reservation_station dut (
        .clk(clk), .rst(rst), .flush(flush), .rs_alu_full(rs_alu_full),
        .rs_alu_we(rs_alu_we), .rs_alu_op(rs_alu_op),
        .rs_alu_vj(rs_alu_vj), .rs_alu_vk(rs_alu_vk),
        .rs_alu_qj(rs_alu_qj), .rs_alu_qk(rs_alu_qk),
        .rs_alu_qj_valid(rs_alu_qj_valid), .rs_alu_qk_valid(rs_alu_qk_valid),
        .rs_alu_dest(rs_alu_dest), .rs_alu_imm(rs_alu_imm), .rs_alu_pc(rs_alu_pc),
        .rs_alu_pred_target(rs_alu_pred_target),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_pred_target(alu_pred_target), .alu_dest(alu_dest)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int sel;
        int fr;
        if (rst || flush) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            e_valid = 1'b0; e_op = 4'd0; e_dest = 4'd0;
            e_vj = 32'd0; e_vk = 32'd0; e_imm = 32'd0; e_pc = 32'd0; e_pt = 32'd0;
        end else begin
            sel = -1;
            fr  = -1;
            for (int i = 0; i < N; i++) begin
                if (sel < 0 && m_busy[i] && !m_qjv[i] && !m_qkv[i]) sel = i;
                if (fr < 0 && !m_busy[i]) fr = i;
            end
            for (int i = 0; i < N; i++) begin
                if (m_busy[i] && cdb_valid && m_qjv[i] && m_qj[i] == cdb_rob_id) begin
                    m_vj[i] = cdb_value; m_qjv[i] = 1'b0;
                end
                if (m_busy[i] && cdb_valid && m_qkv[i] && m_qk[i] == cdb_rob_id) begin
                    m_vk[i] = cdb_value; m_qkv[i] = 1'b0;
                end
            end
            if (sel >= 0 && (!e_valid || alu_ready)) begin
                e_valid = 1'b1; e_op = m_op[sel]; e_dest = m_dest[sel];
                e_vj = m_vj[sel]; e_vk = m_vk[sel]; e_imm = m_imm[sel];
                e_pc = m_pc[sel]; e_pt = m_pt[sel];
                m_busy[sel] = 1'b0;
            end else if (alu_ready) begin
                e_valid = 1'b0;
            end
            if (rs_alu_we && fr >= 0) begin
                m_busy[fr] = 1'b1;
                m_op[fr] = rs_alu_op; m_dest[fr] = rs_alu_dest;
                m_qj[fr] = rs_alu_qj; m_qk[fr] = rs_alu_qk;
                m_imm[fr] = rs_alu_imm; m_pc[fr] = rs_alu_pc; m_pt[fr] = rs_alu_pred_target;
                if (rs_alu_qj_valid && cdb_valid && cdb_rob_id == rs_alu_qj) begin
                    m_vj[fr] = cdb_value; m_qjv[fr] = 1'b0;
                end else begin
                    m_vj[fr] = rs_alu_vj; m_qjv[fr] = rs_alu_qj_valid;
                end
                if (rs_alu_qk_valid && cdb_valid && cdb_rob_id == rs_alu_qk) begin
                    m_vk[fr] = cdb_value; m_qkv[fr] = 1'b0;
                end else begin
                    m_vk[fr] = rs_alu_vk; m_qkv[fr] = rs_alu_qk_valid;
                end
            end
        end
    endtask

    task automatic cycle();
        bit all_busy;
        model_step();
        @(posedge clk);
        #1;
        all_busy = 1'b1;
        for (int i = 0; i < N; i++) all_busy = all_busy & m_busy[i];
        check_val("alu_valid", 32'(alu_valid), 32'(e_valid));
        check_val("rs_alu_full", 32'(rs_alu_full), 32'(all_busy));
        check_val("alu_op", 32'(alu_op), 32'(e_op));
        check_val("alu_dest", 32'(alu_dest), 32'(e_dest));
        check_val("alu_vj", alu_vj, e_vj);
        check_val("alu_vk", alu_vk, e_vk);
        check_val("alu_imm", alu_imm, e_imm);
        check_val("alu_pc", alu_pc, e_pc);
        check_val("alu_pred_target", alu_pred_target, e_pt);
    endtask

    task automatic set_wr(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [3:0] qj, input bit qjv, input logic [3:0] qk,
                          input bit qkv, input logic [3:0] dest);
        rs_alu_we = 1'b1; rs_alu_op = op; rs_alu_vj = vj; rs_alu_vk = vk;
        rs_alu_qj = qj; rs_alu_qj_valid = qjv; rs_alu_qk = qk; rs_alu_qk_valid = qkv;
        rs_alu_dest = dest; rs_alu_imm = vj + 32'd1;
        rs_alu_pc = 32'h1000 + {26'd0, dest, 2'b00}; rs_alu_pred_target = rs_alu_pc + 32'd8;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rs_alu_we = 1'b0; alu_ready = 1'b0; cdb_valid = 1'b0;
        cdb_rob_id = 4'd0; cdb_value = 32'd0;
        set_wr(ALU_ADD, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        rs_alu_we = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0; m_qjv[i] = 1'b0; m_qkv[i] = 1'b0;
        end

        // Reset
        cycle(); cycle();
        rst = 1'b0;
        check_val("reset_valid", 32'(alu_valid), 32'd0);
        check_val("reset_full", 32'(rs_alu_full), 32'd0);
        check_val("reset_dest", 32'(alu_dest), 32'd0);

        // Both operands ready: output two edges after the write
        alu_ready = 1'b1;
        set_wr(ALU_ADD, 32'd5, 32'd7, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3);
        cycle();
        rs_alu_we = 1'b0;
        check_val("ready_not_yet", 32'(alu_valid), 32'd0);
        cycle();
        check_val("ready_valid", 32'(alu_valid), 32'd1);
        check_val("ready_vj", alu_vj, 32'd5);
        check_val("ready_vk", alu_vk, 32'd7);
        check_val("ready_dest", 32'(alu_dest), 32'd3);
        cycle();

        // Pending operand woken by the CDB
        set_wr(ALU_SUB, 32'd0, 32'd9, 4'd4, 1'b1, 4'd0, 1'b0, 4'd4);
        cycle();
        rs_alu_we = 1'b0;
        repeat (3) begin
            cycle();
            check_val("pending_hold", 32'(alu_valid), 32'd0);
        end
        cdb_valid = 1'b1; cdb_rob_id = 4'd4; cdb_value = 32'h1234;
        cycle();
        cdb_valid = 1'b0;
        check_val("wake_not_yet", 32'(alu_valid), 32'd0);
        cycle();
        check_val("wake_valid", 32'(alu_valid), 32'd1);
        check_val("wake_vj", alu_vj, 32'h1234);
        cycle();

        // CDB in the same cycle as the write captures both operands
        set_wr(ALU_XOR, 32'd1, 32'd2, 4'd5, 1'b1, 4'd5, 1'b1, 4'd5);
        cdb_valid = 1'b1; cdb_rob_id = 4'd5; cdb_value = 32'hABCD;
        cycle();
        rs_alu_we = 1'b0; cdb_valid = 1'b0;
        cycle();
        check_val("bypass_valid", 32'(alu_valid), 32'd1);
        check_val("bypass_vj", alu_vj, 32'hABCD);
        check_val("bypass_vk", alu_vk, 32'hABCD);
        cycle();
        check_val("bypass_drained", 32'(alu_valid), 32'd0);

        // Fill with pending entries, ninth write ignored, then drain in order
        alu_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_wr(4'(i), 32'(i * 16), 32'(i), 4'(i + 1), 1'b1, 4'd0, 1'b0, 4'(i));
            cycle();
            check_val("fill_full", 32'(rs_alu_full), (i == N - 1) ? 32'd1 : 32'd0);
        end
        set_wr(ALU_OR, 32'hDEAD, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15);
        cycle();
        rs_alu_we = 1'b0;
        check_val("ninth_ignored_full", 32'(rs_alu_full), 32'd1);
        for (int t = 1; t <= N; t++) begin
            cdb_valid = 1'b1; cdb_rob_id = 4'(t); cdb_value = 32'(100 + t);
            cycle();
            if (t == 1) check_val("full_before_dispatch", 32'(rs_alu_full), 32'd1);
            if (t == 2) check_val("full_after_dispatch", 32'(rs_alu_full), 32'd0);
        end
        cdb_valid = 1'b0;
        check_val("drain_first_dest", 32'(alu_dest), 32'd0);
        alu_ready = 1'b1;
        for (int k = 1; k < N; k++) begin
            cycle();
            check_val("drain_dest", 32'(alu_dest), 32'(k));
            check_val("drain_vj", alu_vj, 32'(101 + k));
        end
        cycle();
        check_val("drain_done", 32'(alu_valid), 32'd0);

        // Backpressure: output holds while alu_ready is low
        alu_ready = 1'b0;
        set_wr(ALU_SUB, 32'h99, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9);
        cycle();
        set_wr(ALU_SUB, 32'hA0, 32'd2, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10);
        cycle();
        rs_alu_we = 1'b0;
        repeat (3) begin
            cycle();
            check_val("bp_valid", 32'(alu_valid), 32'd1);
            check_val("bp_dest", 32'(alu_dest), 32'd9);
            check_val("bp_vj", alu_vj, 32'h99);
        end
        alu_ready = 1'b1;
        cycle();
        check_val("bp_next_dest", 32'(alu_dest), 32'd10);
        cycle();

        // Flush with five busy entries and a held output
        alu_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_wr(ALU_AND, 32'(i), 32'(i), 4'd0, 1'b0, 4'd0, 1'b0, 4'(i + 1));
            cycle();
        end
        rs_alu_we = 1'b0;
        check_val("preflush_valid", 32'(alu_valid), 32'd1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check_val("flush_valid", 32'(alu_valid), 32'd0);
        check_val("flush_full", 32'(rs_alu_full), 32'd0);
        alu_ready = 1'b1;
        repeat (4) begin
            cycle();
            check_val("post_flush_idle", 32'(alu_valid), 32'd0);
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 79) == 0);
            set_wr(4'($urandom_range(0, 15)), $urandom, $urandom,
                   4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)));
            rs_alu_we  = ($urandom_range(0, 99) < 55);
            cdb_valid  = ($urandom_range(0, 1) == 1);
            cdb_rob_id = 4'($urandom_range(0, 7));
            cdb_value  = $urandom;
            alu_ready  = ($urandom_range(0, 99) < 65);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
